// File: rtl/dm_cache_refill_ctrl.sv
// Miss/refill and write-through controller for a 16-line direct-mapped cache array.
// Optional hit/miss statistics counters are enabled by defining DM_CACHE_STATS_EN.
module dm_cache_refill_ctrl #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_hit,
    output logic [ADDR_W-1:0] cache_addr,
    output logic [DATA_W-1:0] cache_din,
    output logic              cache_we,
    input  logic [DATA_W-1:0] cache_dout,
    input  logic              cache_hit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
`ifdef DM_CACHE_STATS_EN
    ,
    output logic [STAT_W-1:0] hit_count,
    output logic [STAT_W-1:0] miss_count
`endif
);

    // Handshakes: cpu_req is taken only in IDLE; mem_req stays high until a
    // one-cycle mem_ack, and an ack seen while mem_req is low has no effect.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_MEM_RD = 3'd2,
        S_FILL   = 3'd3,
        S_MEM_WR = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] fill_data;
    logic              hit_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cpu_busy  = 1'b1;
        cpu_done  = 1'b0;
        cache_we  = 1'b0;
        cache_din = lat_wdata;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        case (state)
            S_IDLE: begin
                cpu_busy = 1'b0;
                if (cpu_req) begin
                    state_nxt = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (lat_we) begin
                    cache_we  = 1'b1;
                    state_nxt = S_MEM_WR;
                end else if (cache_hit) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                cache_we  = 1'b1;
                cache_din = fill_data;
                state_nxt = S_DONE;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                cpu_done  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Both address ports come straight from the latch, so they cannot move mid-access.
    assign cache_addr = lat_addr;
    assign mem_addr   = lat_addr;
    assign mem_wdata  = lat_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            fill_data <= '0;
            hit_flag  <= 1'b0;
            cpu_rdata <= '0;
            cpu_hit   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cpu_req) begin
                        lat_we    <= cpu_we;
                        lat_addr  <= cpu_addr;
                        lat_wdata <= cpu_wdata;
                    end
                end
                S_LOOKUP: begin
                    if (lat_we) begin
                        hit_flag <= cache_hit;
                    end else if (cache_hit) begin
                        cpu_rdata <= cache_dout;
                        cpu_hit   <= 1'b1;
                    end
                end
                S_MEM_RD: begin
                    if (mem_ack) begin
                        fill_data <= mem_rdata;
                    end
                end
                S_FILL: begin
                    cpu_rdata <= fill_data;
                    cpu_hit   <= 1'b0;
                end
                S_MEM_WR: begin
                    if (mem_ack) begin
                        cpu_hit <= hit_flag;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef DM_CACHE_STATS_EN
    // cpu_hit is already final in the DONE cycle, so it classifies the access.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == S_DONE) begin
            if (cpu_hit) begin
                if (hit_count != {STAT_W{1'b1}}) begin
                    hit_count <= hit_count + 1'b1;
                end
            end else begin
                if (miss_count != {STAT_W{1'b1}}) begin
                    miss_count <= miss_count + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_dm_cache_refill_ctrl.sv
// Bench for dm_cache_refill_ctrl: behavioural array/memory environment, access-level
// reference model with expected queue, per-cycle compare process. Honours DM_CACHE_STATS_EN.
module tb_dm_cache_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [10:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_busy, cpu_done, cpu_hit;
    logic [7:0]  cpu_rdata;
    logic [10:0] cache_addr, mem_addr;
    logic [7:0]  cache_din, cache_dout, mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic        cache_we, cache_hit, mem_req, mem_we;
    logic        mem_ack = 1'b0;
`ifdef DM_CACHE_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif

    dm_cache_refill_ctrl dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
        .cache_addr(cache_addr), .cache_din(cache_din), .cache_we(cache_we),
        .cache_dout(cache_dout), .cache_hit(cache_hit),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef DM_CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input int a);
        logic [31:0] v;
        v = a * 37 + 11;
        return (a == 'h784) ? 8'h5C : v[7:0];
    endfunction

    // environment: cache array (written by DUT strobes) and main memory
    logic [3:0] env_tag[16];
    logic [7:0] env_data[16];
    logic       env_v[16];
    logic       env_clr = 1'b1;
    logic [7:0] env_mem[2048];

    assign cache_hit  = env_v[cache_addr[3:0]] && (env_tag[cache_addr[3:0]] == cache_addr[10:7]);
    assign cache_dout = env_data[cache_addr[3:0]];

    always @(posedge clk) begin
        if (env_clr) begin
            for (int i = 0; i < 16; i++) env_v[i] <= 1'b0;
        end else if (cache_we) begin
            env_v[cache_addr[3:0]]    <= 1'b1;
            env_tag[cache_addr[3:0]]  <= cache_addr[10:7];
            env_data[cache_addr[3:0]] <= cache_din;
        end
    end

    logic resp_en = 1'b1;
    logic force_ack = 1'b0;
    int   mem_n = 0;

    initial begin
        int wait_cnt;
        wait_cnt = 0;
        for (int i = 0; i < 2048; i++) env_mem[i] = init_byte(i);
        forever begin
            @(negedge clk);
            if (!resp_en) begin
                mem_ack  = force_ack;
                wait_cnt = 0;
            end else begin
                mem_ack = 1'b0;
                if (mem_req) begin
                    if (wait_cnt == mem_n) begin
                        mem_ack = 1'b1;
                        if (mem_we) env_mem[mem_addr] = mem_wdata;
                        else mem_rdata = env_mem[mem_addr];
                        wait_cnt = 0;
                    end else begin
                        wait_cnt++;
                    end
                end else begin
                    wait_cnt = 0;
                end
            end
        end
    end

    // reference model (access level)
    logic [3:0]  mdl_tag[16];
    logic [7:0]  mdl_data[16];
    logic        mdl_v[16];
    logic [7:0]  mdl_mem[2048];
    logic [7:0]  last_rdata = '0;
    int          mdl_lat = 0;
    int          exp_hits = 0;
    int          exp_miss = 0;
    logic [16:0] exp_q[$];

    logic [10:0] cur_addr = '0;
    logic        cur_we = 1'b0;
    logic        cur_mem = 1'b0;
    logic [7:0]  cur_din = '0;
    logic [7:0]  cur_wdata = '0;
    int          cur_cw = 0;

    int issued_n = 0;
    int done_n = 0;
    int abort_n = 0;
    logic chk_off = 1'b0;

    function automatic logic active();
        return issued_n != (done_n + abort_n);
    endfunction

    // compare process
    initial begin
        int lat_cnt;
        int cw_cnt;
        logic [16:0] e;
        lat_cnt = 0;
        cw_cnt = 0;
        forever begin
            @(negedge clk);
            if (!chk_off && !rst) begin
                if (active()) begin
                    lat_cnt++;
                    check("busy", cpu_busy, 1);
                    check("cache_addr", cache_addr, cur_addr);
                    check("mem_addr", mem_addr, cur_addr);
                    if (!cur_mem) check("no_mem_req", mem_req, 0);
                    if (mem_req) check("mem_we", mem_we, cur_we);
                    if (mem_req && mem_we) check("mem_wdata", mem_wdata, cur_wdata);
                    if (cache_we) begin
                        cw_cnt++;
                        check("cache_din", cache_din, cur_din);
                    end
                    if (cpu_done) begin
                        if (exp_q.size() == 0) begin
                            check("exp_q_empty", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            check("cpu_rdata", cpu_rdata, e[16:9]);
                            check("cpu_hit", cpu_hit, e[8]);
                            check("latency", lat_cnt, e[7:0]);
                        end
                        check("cache_we_count", cw_cnt, cur_cw);
                        check("done_mem_req", mem_req, 0);
                        check("done_cache_we", cache_we, 0);
                        done_n++;
                    end
                end else begin
                    lat_cnt = 0;
                    cw_cnt = 0;
                    check("idle_busy", cpu_busy, 0);
                    check("idle_done", cpu_done, 0);
                    check("idle_mem_req", mem_req, 0);
                    check("idle_cache_we", cache_we, 0);
                end
            end
        end
    end

    // driver
    task automatic do_access(input logic we, input logic [10:0] addr, input logic [7:0] wdata,
                             input int n);
        logic [3:0] idx;
        logic hit;
        logic [7:0] rd;
        int lat;
        int k;
        idx = addr[3:0];
        hit = mdl_v[idx] && (mdl_tag[idx] == addr[10:7]);
        if (we) begin
            rd = last_rdata;
            lat = 3 + n;
            cur_din = wdata;
            mdl_mem[addr] = wdata;
            mdl_v[idx] = 1'b1; mdl_tag[idx] = addr[10:7]; mdl_data[idx] = wdata;
        end else if (hit) begin
            rd = mdl_data[idx];
            lat = 2;
            cur_din = '0;
        end else begin
            rd = mdl_mem[addr];
            lat = 4 + n;
            cur_din = rd;
            mdl_v[idx] = 1'b1; mdl_tag[idx] = addr[10:7]; mdl_data[idx] = rd;
        end
        if (hit) exp_hits++;
        else exp_miss++;
        last_rdata = rd;
        mdl_lat = lat;
        exp_q.push_back({rd, hit, lat[7:0]});
        cur_addr = addr; cur_we = we; cur_wdata = wdata;
        cur_mem = we || !hit;
        cur_cw = (we || !hit) ? 1 : 0;
        mem_n = n;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        @(posedge clk);
        #1;
        issued_n++;
        cpu_req = 1'b0;
        cpu_addr = 11'($urandom); cpu_wdata = 8'($urandom); cpu_we = 1'($urandom);
        k = 0;
        while (active() && k < 100) begin
            @(negedge clk);
            k++;
            if (active()) cpu_req = 1'($urandom_range(0, 1));
        end
        cpu_req = 1'b0;
        if (active()) begin
            total++;
            bad++;
            $display("FAIL timeout: access to %0h not done after %0d cycles, want %0d", addr, k, lat);
            abort_n++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int m0;
        for (int i = 0; i < 2048; i++) mdl_mem[i] = init_byte(i);
        for (int i = 0; i < 16; i++) mdl_v[i] = 1'b0;

        // 1: reset with cpu_req held high
        rst = 1'b1; env_clr = 1'b1; cpu_req = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rst_busy", cpu_busy, 0);
            check("rst_done", cpu_done, 0);
            check("rst_mem_req", mem_req, 0);
            check("rst_cache_we", cache_we, 0);
            check("rst_rdata", cpu_rdata, 8'h00);
            check("rst_hit", cpu_hit, 0);
        end
        cpu_req = 1'b0; rst = 1'b0; env_clr = 1'b0;
        @(negedge clk);

        // 2: write-through miss, ack 3 cycles after mem_req
        do_access(1'b1, 11'h080, 8'hA1, 3);
        check("t2_model_lat", mdl_lat, 6);
        // 3: read hit
        do_access(1'b0, 11'h080, 8'h00, 0);
        check("t3_model_lat", mdl_lat, 2);
        check("t3_rdata", cpu_rdata, 8'hA1);
        check("t3_hit", cpu_hit, 1);
        // 4: read miss with refill
        do_access(1'b0, 11'h784, 8'h00, 2);
        check("t4_model_lat", mdl_lat, 6);
        check("t4_rdata", cpu_rdata, 8'h5C);
        check("t4_hit", cpu_hit, 0);
        // 5: conflict eviction
        m0 = exp_miss;
        do_access(1'b1, 11'h480, 8'h9A, 1);
        check("t5w_hit", cpu_hit, 0);
        do_access(1'b0, 11'h080, 8'h00, 0);
        check("t5_rdata", cpu_rdata, 8'hA1);
        check("t5_hit", cpu_hit, 0);
        check("t5_miss_delta_model", exp_miss - m0, 2);
        @(negedge clk);
`ifdef DM_CACHE_STATS_EN
        check("t5_miss_count", miss_count, exp_miss);
        check("t5_hit_count", hit_count, exp_hits);
`endif

        // 6: reset during MEM_RD wait, late ack afterwards
        chk_off = 1'b1; resp_en = 1'b0; force_ack = 1'b0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h10B;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t6_wait1_mem_req", mem_req, 1);
        @(negedge clk);
        check("t6_wait2_mem_req", mem_req, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; force_ack = 1'b1;
        @(negedge clk);
        check("t6_mem_req_dropped", mem_req, 0);
        check("t6_busy", cpu_busy, 0);
        @(posedge clk);
        #1 force_ack = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("t6_busy_after", cpu_busy, 0);
            check("t6_no_done", cpu_done, 0);
            check("t6_no_cache_we", cache_we, 0);
            check("t6_no_mem_req", mem_req, 0);
        end
        check("t6_line_untouched", env_v[11], 0);
        check("t6_rdata_cleared", cpu_rdata, 8'h00);
        last_rdata = '0; exp_hits = 0; exp_miss = 0;
        resp_en = 1'b1; chk_off = 1'b0;

        // randomized phase
        for (int t = 0; t < 150; t++) begin
            logic [10:0] a;
            a = {2'b00, 2'($urandom_range(0, 3)), 3'($urandom), 4'($urandom)};
            do_access(($urandom_range(0, 2) == 0), a, 8'($urandom), $urandom_range(0, 4));
        end
        @(negedge clk);
        @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
`ifdef DM_CACHE_STATS_EN
        check("final_hit_count", hit_count, exp_hits);
        check("final_miss_count", miss_count, exp_miss);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
